nway_set_assoc_cache: RTL

NWAY_SET_ASSOC_CACHE -- requirements
Module: nway_set_assoc_cache

---
 rtl/nway_set_assoc_cache_if.sv | 30 +++
 rtl/nway_set_assoc_cache.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nway_set_assoc_cache_if.sv
// CPU-side request/response and memory-side line transfer signals of the cache.
// The cache attaches through the slave modport, the CPU/memory side through master.
interface nway_set_assoc_cache_if #(
    parameter int LINE_WIDTH = 128
);
    logic [31:0]           addr;
    logic                  r_req;
    logic                  w_req;
    logic [31:0]           w_data;
    logic [31:0]           r_data;
    logic                  miss;
    logic                  mem_r;
    logic                  mem_w;
    logic [31:0]           mem_addr;
    logic [LINE_WIDTH-1:0] mem_w_data;
    logic [LINE_WIDTH-1:0] mem_r_data;
    logic                  mem_ready;
    logic [31:0]           hit_cnt;
    logic [31:0]           miss_cnt;

    modport slave (
        input  addr, r_req, w_req, w_data, mem_r_data, mem_ready,
        output r_data, miss, mem_r, mem_w, mem_addr, mem_w_data, hit_cnt, miss_cnt
    );

    modport master (
        output addr, r_req, w_req, w_data, mem_r_data, mem_ready,
        input  r_data, miss, mem_r, mem_w, mem_addr, mem_w_data, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/nway_set_assoc_cache.sv
// N-way set-associative write-back cache, one-cycle hit, LRU or LFSR replacement.
// Valid/dirty/age state lives in resettable flops; tags and lines in sync-read arrays.
module nway_set_assoc_cache #(
    parameter int INDEX_WIDTH       = 3,
    parameter int LINE_OFFSET_WIDTH = 2,
    parameter int WAY_NUM           = 4,
    parameter int REPLACE_MODE      = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    nway_set_assoc_cache_if.slave bus
);
    localparam int SET_NUM    = 1 << INDEX_WIDTH;
    localparam int LINE_WIDTH = 32 << LINE_OFFSET_WIDTH;
    localparam int LSB        = LINE_OFFSET_WIDTH + 2;
    localparam int TAG_W      = 32 - INDEX_WIDTH - LSB;
    localparam int WAY_W      = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WBACK, S_REFILL, S_FILL} state_t;
    typedef logic [WAY_NUM-1:0][WAY_W-1:0] ages_t;

    state_t                             r_state, w_next;
    logic [31:0]                        r_addr, r_wdata;
    logic                               r_op;
    logic [WAY_NUM-1:0]                 r_valid [SET_NUM];
    logic [WAY_NUM-1:0]                 r_dirty [SET_NUM];
    ages_t                              r_age   [SET_NUM];
    logic [TAG_W-1:0]                   r_tag_mem  [WAY_NUM][SET_NUM];
    logic [LINE_WIDTH-1:0]              r_line_mem [WAY_NUM][SET_NUM];
    logic [WAY_NUM-1:0][TAG_W-1:0]      r_tag_q;
    logic [WAY_NUM-1:0][LINE_WIDTH-1:0] r_line_q;
    logic [LINE_WIDTH-1:0]              r_fill_line;
    logic [WAY_W-1:0]                   r_victim;
    logic [15:0]                        r_lfsr;
    logic [31:0]                        r_hit_cnt, r_miss_cnt;

    logic [INDEX_WIDTH-1:0]       w_idx, w_rd_idx;
    logic [TAG_W-1:0]             w_tag;
    logic [LINE_OFFSET_WIDTH-1:0] w_off;
    logic                         w_new_req, w_hit, w_rd_en, w_wr_en, w_lru_upd, w_inv_found;
    logic [WAY_NUM-1:0]           w_hit_vec;
    logic [WAY_W-1:0]             w_hit_way, w_victim, w_wr_way, w_lru_way;
    logic [LINE_WIDTH-1:0]        w_wr_line;
    ages_t                        w_age_nxt;
    logic                         w_miss, w_mem_r, w_mem_w;
    logic [31:0]                  w_mem_addr, w_rdata;
    logic [LINE_WIDTH-1:0]        w_mem_wdata;

    assign w_idx     = r_addr[LSB +: INDEX_WIDTH];
    assign w_tag     = r_addr[31 -: TAG_W];
    assign w_off     = r_addr[2 +: LINE_OFFSET_WIDTH];
    assign w_rd_idx  = bus.addr[LSB +: INDEX_WIDTH];
    assign w_new_req = bus.r_req | bus.w_req;
    assign w_rd_en   = w_new_req && ((r_state == S_IDLE) || w_hit);

    function automatic logic [LINE_WIDTH-1:0] merge_word(input logic [LINE_WIDTH-1:0] line,
                                                         input logic [LINE_OFFSET_WIDTH-1:0] off,
                                                         input logic [31:0] d);
        logic [LINE_WIDTH-1:0] m;
        m = line;
        m[off*32 +: 32] = d;
        return m;
    endfunction

    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        for (int w = 0; w < WAY_NUM; w++)
            w_hit_vec[w] = r_valid[w_idx][w] && (r_tag_q[w] == w_tag);
        for (int w = WAY_NUM - 1; w >= 0; w--)
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
        w_hit = (r_state == S_LOOKUP) && (|w_hit_vec);
    end

    // Invalid ways are always preferred; replacement policy only breaks ties on a full set.
    always_comb begin
        w_victim    = '0;
        w_inv_found = 1'b0;
        for (int w = 0; w < WAY_NUM; w++)
            if (!r_valid[w_idx][w] && !w_inv_found) begin
                w_victim    = WAY_W'(w);
                w_inv_found = 1'b1;
            end
        if (!w_inv_found && WAY_NUM > 1) begin
            if (REPLACE_MODE == 0) begin
                for (int w = 0; w < WAY_NUM; w++)
                    if (r_age[w_idx][w] == WAY_W'(WAY_NUM - 1)) w_victim = WAY_W'(w);
            end else begin
                w_victim = r_lfsr[WAY_W-1:0];
            end
        end
    end

    always_comb begin
        w_lru_upd = w_hit || (r_state == S_FILL);
        w_lru_way = (r_state == S_FILL) ? r_victim : w_hit_way;
        w_age_nxt = r_age[w_idx];
        for (int w = 0; w < WAY_NUM; w++)
            if (r_age[w_idx][w] < r_age[w_idx][w_lru_way]) w_age_nxt[w] = r_age[w_idx][w] + 1'b1;
        w_age_nxt[w_lru_way] = '0;
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_way  = w_hit_way;
        w_wr_line = merge_word(r_line_q[w_hit_way], w_off, r_wdata);
        if (w_hit && r_op) begin
            w_wr_en = 1'b1;
        end else if (r_state == S_FILL) begin
            w_wr_en   = 1'b1;
            w_wr_way  = r_victim;
            w_wr_line = r_op ? merge_word(r_fill_line, w_off, r_wdata) : r_fill_line;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag_mem[w_wr_way][w_idx]  <= w_tag;
            r_line_mem[w_wr_way][w_idx] <= w_wr_line;
        end
    end

    // A write hit and the next lookup can target the same set in one cycle: forward the write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tag_q  <= '0;
            r_line_q <= '0;
        end else if (w_rd_en) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                if (w_wr_en && w_wr_way == WAY_W'(w) && w_idx == w_rd_idx) begin
                    r_tag_q[w]  <= w_tag;
                    r_line_q[w] <= w_wr_line;
                end else begin
                    r_tag_q[w]  <= r_tag_mem[w][w_rd_idx];
                    r_line_q[w] <= r_line_mem[w][w_rd_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_op        <= 1'b0;
            r_victim    <= '0;
            r_fill_line <= '0;
            r_lfsr      <= 16'hACE1;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            for (int s = 0; s < SET_NUM; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAY_NUM; w++) r_age[s][w] <= WAY_W'(w);
            end
        end else begin
            r_state <= w_next;
            r_lfsr  <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
            if (w_rd_en) begin
                r_addr  <= bus.addr;
                r_wdata <= bus.w_data;
                r_op    <= bus.w_req & ~bus.r_req;
            end
            if (r_state == S_LOOKUP) begin
                if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
                else begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                    r_victim   <= w_victim;
                end
            end
            if (r_state == S_REFILL && bus.mem_ready) r_fill_line <= bus.mem_r_data;
            if (w_wr_en) begin
                r_valid[w_idx][w_wr_way] <= 1'b1;
                r_dirty[w_idx][w_wr_way] <= r_op;
            end
            if (w_lru_upd && WAY_NUM > 1) r_age[w_idx] <= w_age_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_miss      = 1'b0;
        w_mem_r     = 1'b0;
        w_mem_w     = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_rdata     = '0;
        case (r_state)
            S_IDLE: if (w_new_req) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (w_hit) begin
                    if (!r_op) w_rdata = r_line_q[w_hit_way][w_off*32 +: 32];
                    w_next = w_new_req ? S_LOOKUP : S_IDLE;
                end else begin
                    w_miss = 1'b1;
                    w_next = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? S_WBACK : S_REFILL;
                end
            end
            S_WBACK: begin
                w_miss      = 1'b1;
                w_mem_w     = 1'b1;
                w_mem_addr  = {r_tag_q[r_victim], w_idx, {LSB{1'b0}}};
                w_mem_wdata = r_line_q[r_victim];
                if (bus.mem_ready) w_next = S_REFILL;
            end
            S_REFILL: begin
                w_miss     = 1'b1;
                w_mem_r    = 1'b1;
                w_mem_addr = {r_addr[31:LSB], {LSB{1'b0}}};
                if (bus.mem_ready) w_next = S_FILL;
            end
            S_FILL: begin
                w_rdata = r_fill_line[w_off*32 +: 32];
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.r_data     = w_rdata;
    assign bus.miss       = w_miss;
    assign bus.mem_r      = w_mem_r;
    assign bus.mem_w      = w_mem_w;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_w_data = w_mem_wdata;
    assign bus.hit_cnt    = r_hit_cnt;
    assign bus.miss_cnt   = r_miss_cnt;
endmodule
